// File: rtl/rs_dsp_div.sv
// rs_dsp_div: sequential radix-2 restoring divider, Z_WIDTH dividend by B_WIDTH divisor.
// Produces an A_WIDTH quotient (truncated toward zero) and a B_WIDTH+1 remainder carrying the dividend sign.
module rs_dsp_div #(
    parameter int unsigned A_WIDTH = 20,
    parameter int unsigned B_WIDTH = 18
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [A_WIDTH+B_WIDTH-1:0]   z,
    input  logic [B_WIDTH-1:0]           b,
    input  logic                         unsigned_a,
    input  logic                         unsigned_b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [A_WIDTH-1:0]           q,
    output logic [B_WIDTH:0]             r,
    output logic                         div_by_zero,
    output logic                         overflow
);

    localparam int unsigned Z_WIDTH = A_WIDTH + B_WIDTH;
    localparam int unsigned R_WIDTH = B_WIDTH + 1;
    localparam int unsigned C_WIDTH = $clog2(A_WIDTH + 1);

    // Signed quotient limits: most negative pattern doubles as the largest legal negative magnitude
    localparam logic [A_WIDTH-1:0] Q_MIN_NEG = {1'b1, {(A_WIDTH-1){1'b0}}};
    localparam logic [A_WIDTH-1:0] Q_MAX_POS = {1'b0, {(A_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [A_WIDTH-1:0]   r_q;
    logic [R_WIDTH-1:0]   r_r;
    logic                 r_dz_out;
    logic                 r_ovf_out;

    logic [A_WIDTH-1:0]   r_zlo;      // low dividend bits shift out MSB first, quotient bits shift in
    logic [B_WIDTH-1:0]   r_pr;       // partial remainder, always < |b| for a legal division
    logic [B_WIDTH-1:0]   r_bmag;
    logic [C_WIDTH-1:0]   r_cnt;
    logic                 r_z_neg;
    logic                 r_b_neg;
    logic                 r_q_signed;
    logic                 r_dz;
    logic                 r_ovf_pre;

    logic                 w_accept;
    logic                 w_z_neg;
    logic                 w_b_neg;
    logic [Z_WIDTH-1:0]   w_z_mag;
    logic [B_WIDTH-1:0]   w_b_mag;
    logic                 w_b_zero;
    logic                 w_ovf_pre;
    logic [R_WIDTH-1:0]   w_shift;
    logic                 w_ge;
    logic [B_WIDTH-1:0]   w_sub;
    logic                 w_q_neg;
    logic                 w_ovf_rng;

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign q           = r_q;
    assign r           = r_r;
    assign div_by_zero = r_dz_out;
    assign overflow    = r_ovf_out;

    // Operand conditioning at accept: magnitudes, signs and early exception checks
    assign w_accept  = in_valid && r_in_ready;
    assign w_z_neg   = !unsigned_a && z[Z_WIDTH-1];
    assign w_b_neg   = !unsigned_b && b[B_WIDTH-1];
    assign w_z_mag   = w_z_neg ? (~z + Z_WIDTH'(1)) : z;
    assign w_b_mag   = w_b_neg ? (~b + B_WIDTH'(1)) : b;
    assign w_b_zero  = (w_b_mag == '0);
    assign w_ovf_pre = !w_b_zero && (w_z_mag[Z_WIDTH-1:A_WIDTH] >= w_b_mag);

    // One restoring step: shift next dividend bit in, subtract |b| when it fits
    assign w_shift = {r_pr, r_zlo[A_WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_bmag});
    assign w_sub   = w_shift[B_WIDTH-1:0] - r_bmag;

    // Result sign and signed-range check on the unsigned quotient magnitude
    assign w_q_neg   = r_z_neg ^ r_b_neg;
    assign w_ovf_rng = r_q_signed && (w_q_neg ? (r_zlo > Q_MIN_NEG) : r_zlo[A_WIDTH-1]);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_CALC;
            S_CALC: if (r_cnt == C_WIDTH'(A_WIDTH - 1)) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Registered handshake outputs follow the state being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_next == S_IDLE);
            r_out_valid <= (w_next == S_DONE);
        end
    end

    // Datapath: load at accept, iterate in CALC, sign-fix and register results in FIX
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_zlo      <= '0;
            r_pr       <= '0;
            r_bmag     <= '0;
            r_cnt      <= '0;
            r_z_neg    <= 1'b0;
            r_b_neg    <= 1'b0;
            r_q_signed <= 1'b0;
            r_dz       <= 1'b0;
            r_ovf_pre  <= 1'b0;
            r_q        <= '0;
            r_r        <= '0;
            r_dz_out   <= 1'b0;
            r_ovf_out  <= 1'b0;
        end else if (w_accept) begin
            r_zlo      <= w_z_mag[A_WIDTH-1:0];
            r_pr       <= w_z_mag[Z_WIDTH-1:A_WIDTH];
            r_bmag     <= w_b_mag;
            r_cnt      <= '0;
            r_z_neg    <= w_z_neg;
            r_b_neg    <= w_b_neg;
            r_q_signed <= !unsigned_a || !unsigned_b;
            r_dz       <= w_b_zero;
            r_ovf_pre  <= w_ovf_pre;
        end else if (r_state == S_CALC) begin
            r_zlo <= {r_zlo[A_WIDTH-2:0], w_ge};
            r_pr  <= w_ge ? w_sub : w_shift[B_WIDTH-1:0];
            r_cnt <= r_cnt + C_WIDTH'(1);
        end else if (r_state == S_FIX) begin
            if (r_dz) begin
                r_q       <= '1;
                r_r       <= '0;
                r_dz_out  <= 1'b1;
                r_ovf_out <= 1'b0;
            end else if (r_ovf_pre || w_ovf_rng) begin
                r_q       <= !r_q_signed ? '1 : (w_q_neg ? Q_MIN_NEG : Q_MAX_POS);
                r_r       <= '0;
                r_dz_out  <= 1'b0;
                r_ovf_out <= 1'b1;
            end else begin
                r_q       <= w_q_neg ? (~r_zlo + A_WIDTH'(1)) : r_zlo;
                r_r       <= r_z_neg ? (~{1'b0, r_pr} + R_WIDTH'(1)) : {1'b0, r_pr};
                r_dz_out  <= 1'b0;
                r_ovf_out <= 1'b0;
            end
        end
    end

endmodule
